// File: rtl/fifo_pkg.sv
// Shared FIFO definitions used by both the write and the read side.
//   - wstate encodings (2 bits): IDLE=00, WRITE=01, FULL=10
//   - bin2gray / gray2bin conversions on a 32-bit carrier. Callers
//     zero-extend narrower pointers in and truncate the result back out.
package fifo_pkg;

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_WRITE = 2'b01;
  localparam logic [1:0] ST_FULL  = 2'b10;

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // MSB passes straight through; each lower bit is the XOR of all
  // Gray bits at and above it.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int unsigned i = 31; i > 0; i--) begin
      b[i-1] = b[i] ^ g[i-1];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_ptr_sync.sv
// Two-flop synchroniser for a Gray-coded pointer crossing into clk.
// Ports:
//   clk, rst   - destination clock, synchronous active-high reset
//   d          - Gray pointer from the foreign domain
//   q_mid      - first-stage value (only to anticipate what q becomes next)
//   q          - second-stage, synchronised pointer
module fifo_ptr_sync #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q_mid,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;

  always_comb begin
    sync1_d = d;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign q_mid = sync1_q;
  assign q     = sync2_q;

endmodule

// File: rtl/fifo_write_ctrl.sv
// Write-side controller of an asynchronous FIFO.
// Ports:
//   clk, rst      - write clock, synchronous active-high reset
//   winc          - producer write request
//   rptr_gray     - Gray read pointer from the read domain (asynchronous)
//   write_en      - storage write strobe for this cycle
//   waddr         - storage write index
//   waddr_gray    - registered Gray write pointer for the read domain
//   wfull         - registered (pessimistic) full flag
//   walmost_full  - occupancy >= AFULL_THR
//   wlevel        - occupancy as seen from the write domain
//   wstate        - IDLE / WRITE / FULL
module fifo_write_ctrl
  import fifo_pkg::*;
#(
  parameter int PTR_SZ    = 2,
  parameter int AFULL_THR = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              winc,
  input  logic [PTR_SZ:0]   rptr_gray,
  output logic              write_en,
  output logic [PTR_SZ-1:0] waddr,
  output logic [PTR_SZ:0]   waddr_gray,
  output logic              wfull,
  output logic              walmost_full,
  output logic [PTR_SZ:0]   wlevel,
  output logic [1:0]        wstate
);

  localparam int W = PTR_SZ + 1;

  if (PTR_SZ < 2) begin : g_bad_ptr_sz
    $error("fifo_write_ctrl: PTR_SZ must be >= 2");
  end
  if (AFULL_THR < 1 || AFULL_THR > (1 << PTR_SZ)) begin : g_bad_afull
    $error("fifo_write_ctrl: AFULL_THR out of range");
  end

  logic [W-1:0] wq1_rptr;
  logic [W-1:0] wq2_rptr;
  logic [W-1:0] full_cmp;
  logic [W-1:0] wlevel_next;

  logic [W-1:0] wbin_q,   wbin_d;
  logic [W-1:0] wgray_q,  wgray_d;
  logic         wfull_q,  wfull_d;
  logic [1:0]   wstate_q, wstate_d;

  fifo_ptr_sync #(
    .WIDTH (W)
  ) u_rptr_sync (
    .clk   (clk),
    .rst   (rst),
    .d     (rptr_gray),
    .q_mid (wq1_rptr),
    .q     (wq2_rptr)
  );

  // Reset wins over a pending request; a set wfull refuses the write
  // even if the reader has already freed a slot (pessimistic full).
  assign write_en = winc & ~wfull_q & ~rst;

  // Full when our next Gray pointer equals the read pointer with its
  // two MSBs inverted, i.e. exactly one lap ahead.
  assign full_cmp = {~wq2_rptr[PTR_SZ:PTR_SZ-1], wq2_rptr[PTR_SZ-2:0]};

  always_comb begin
    wbin_d  = wbin_q + W'(write_en);
    wgray_d = W'(bin2gray(32'(wbin_d)));
    wfull_d = (bin2gray(32'(wbin_d)) == 32'(full_cmp));
    // Occupancy after this edge: the synchroniser's first stage is what
    // its second stage will hold, so wstate tracks wlevel without lag.
    wlevel_next = W'(32'(wbin_d) - gray2bin(32'(wq1_rptr)));
    if (wfull_d) begin
      wstate_d = ST_FULL;
    end else if (wlevel_next != '0) begin
      wstate_d = ST_WRITE;
    end else begin
      wstate_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wbin_q   <= '0;
      wgray_q  <= '0;
      wfull_q  <= 1'b0;
      wstate_q <= ST_IDLE;
    end else begin
      wbin_q   <= wbin_d;
      wgray_q  <= wgray_d;
      wfull_q  <= wfull_d;
      wstate_q <= wstate_d;
    end
  end

  assign waddr        = wbin_q[PTR_SZ-1:0];
  assign waddr_gray   = wgray_q;
  assign wfull        = wfull_q;
  assign wlevel       = W'(32'(wbin_q) - gray2bin(32'(wq2_rptr)));
  assign walmost_full = (int'(wlevel) >= AFULL_THR);
  assign wstate       = wstate_q;

endmodule

// File: tb/tb_fifo_write_ctrl.sv
module tb_fifo_write_ctrl;

  logic       clk;
  logic       rst;
  logic       winc;
  logic [2:0] rptr_gray;
  logic       write_en;
  logic [1:0] waddr;
  logic [2:0] waddr_gray;
  logic       wfull;
  logic       walmost_full;
  logic [2:0] wlevel;
  logic [1:0] wstate;

  fifo_write_ctrl #(
    .PTR_SZ    (2),
    .AFULL_THR (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .winc         (winc),
    .rptr_gray    (rptr_gray),
    .write_en     (write_en),
    .waddr        (waddr),
    .waddr_gray   (waddr_gray),
    .wfull        (wfull),
    .walmost_full (walmost_full),
    .wlevel       (wlevel),
    .wstate       (wstate)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  // Scoreboard of expected write addresses, pushed when an accepted
  // write is driven, popped when the DUT strobes write_en.
  logic [1:0] sb_q[$];

  // Reference model kept in binary; full is "one whole lap ahead".
  logic [2:0] m_wbin;
  logic [2:0] m_s1, m_s2;
  logic       m_full;

  function automatic logic [2:0] to_gray(input logic [2:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [2:0] from_gray(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = g[2] ^ g[1];
    b[0] = g[2] ^ g[1] ^ g[0];
    return b;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock cycle: drive, check the same-cycle strobe, advance the
  // model across the edge, then check every registered output.
  task automatic tick(input logic r, input logic w, input logic [2:0] rg);
    logic       acc;
    logic [2:0] nb;
    logic [2:0] lvl;
    logic [1:0] e;
    rst = r; winc = w; rptr_gray = rg;
    acc = w && !m_full && !r;
    if (acc) sb_q.push_back(m_wbin[1:0]);
    @(negedge clk);
    check("write_en", 32'(write_en), 32'(acc));
    if (write_en === 1'b1) begin
      check("sb_nonempty", 32'(sb_q.size() > 0), 32'(1));
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_waddr", 32'(waddr), 32'(e));
      end
    end
    @(posedge clk);
    if (r) begin
      m_wbin = '0; m_s1 = '0; m_s2 = '0; m_full = 1'b0;
    end else begin
      nb     = m_wbin + 3'(acc);
      m_full = ((nb - from_gray(m_s2)) == 3'd4);
      m_wbin = nb;
      m_s2   = m_s1;
      m_s1   = rg;
    end
    lvl = m_wbin - from_gray(m_s2);
    #1;
    check("waddr",        32'(waddr),        32'(m_wbin[1:0]));
    check("waddr_gray",   32'(waddr_gray),   32'(to_gray(m_wbin)));
    check("wfull",        32'(wfull),        32'(m_full));
    check("wlevel",       32'(wlevel),       32'(lvl));
    check("walmost_full", 32'(walmost_full), 32'(lvl >= 3'd3));
    check("wstate",       32'(wstate),       m_full ? 32'd2 : (lvl != 0 ? 32'd1 : 32'd0));
  endtask

  logic [2:0] wrap_seq [9];
  logic [2:0] prev_gray;

  initial begin
    wrap_seq = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    rst = 1'b1; winc = 1'b0; rptr_gray = '0;
    m_wbin = '0; m_s1 = '0; m_s2 = '0; m_full = 1'b0;

    // Reset for two cycles
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b1, 1'b0, 3'b000);
    check("rst_waddr",  32'(waddr),      32'd0);
    check("rst_gray",   32'(waddr_gray), 32'b000);
    check("rst_wfull",  32'(wfull),      32'd0);
    check("rst_wlevel", 32'(wlevel),     32'd0);
    check("rst_wstate", 32'(wstate),     32'd0);

    // Fill four entries with the reader parked at 0
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b1, 3'b000);
      if (i == 2) begin
        check("fill_lvl3",  32'(wlevel),       32'd3);
        check("fill_afull", 32'(walmost_full), 32'd1);
      end
    end
    check("fill_gray",   32'(waddr_gray), 32'b110);
    check("fill_wfull",  32'(wfull),      32'd1);
    check("fill_wlevel", 32'(wlevel),     32'd4);
    check("fill_wstate", 32'(wstate),     32'd2);

    // Overflow attempts are dropped
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b000);
    check("ovf_gray",   32'(waddr_gray), 32'b110);
    check("ovf_wlevel", 32'(wlevel),     32'd4);

    // Release: reader moves 000->001 while the producer keeps asking
    tick(1'b0, 1'b1, 3'b001);
    check("rel_e1_wfull", 32'(wfull), 32'd1);
    tick(1'b0, 1'b1, 3'b001);
    check("rel_e2_wfull", 32'(wfull), 32'd1);
    tick(1'b0, 1'b1, 3'b001);
    check("rel_e3_wfull",  32'(wfull),  32'd0);
    check("rel_e3_wlevel", 32'(wlevel), 32'd3);
    check("rel_waddr",     32'(waddr),  32'd0);
    tick(1'b0, 1'b1, 3'b001);
    check("rel_refull", 32'(wfull), 32'd1);

    // Wrap: eight writes with the reader trailing
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b1, 1'b0, 3'b000);
    prev_gray = waddr_gray;
    for (int i = 0; i < 8; i++) begin
      tick(1'b0, 1'b1, to_gray(3'(i)));
      check("wrap_gray", 32'(waddr_gray), 32'(wrap_seq[i+1]));
      check("wrap_1bit", $countones(prev_gray ^ waddr_gray), 32'd1);
      prev_gray = waddr_gray;
    end

    // Reset in the middle of a burst with winc held
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b1, 1'b0, 3'b000);
    tick(1'b0, 1'b1, 3'b000);
    tick(1'b0, 1'b1, 3'b000);
    check("mid_pre_waddr", 32'(waddr), 32'd2);
    tick(1'b1, 1'b1, 3'b000);
    check("mid_waddr",  32'(waddr),  32'd0);
    check("mid_wlevel", 32'(wlevel), 32'd0);
    tick(1'b0, 1'b0, 3'b000);

    check("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
